// File: rtl/hub_linear_fold_sequencer_if.sv
// Control bundle between the fold sequencer (master) and the HUB linear datapath (slave).
interface hub_linear_fold_sequencer_if #(
  parameter int PWID = 2
);
  logic            start;
  logic            ready;
  logic            busy;
  logic            load;
  logic [PWID-1:0] partMul;
  logic [PWID-1:0] partAcc;
  logic            accValid;
  logic            clear;
  logic            sel;
  logic            done;

  modport master (
    input  start,
    output ready, busy, load, partMul, partAcc, accValid, clear, sel, done
  );

  modport slave (
    output start,
    input  ready, busy, load, partMul, partAcc, accValid, clear, sel, done
  );
endinterface

// File: rtl/hub_linear_fold_sequencer.sv
// Sequences one folded HUB linear inference: weight load, FOLD parts of BLEN cycles,
// adder-tree drain, then a done pulse with a double-buffer swap.
module hub_linear_fold_sequencer #(
  parameter int FOLD = 4,
  parameter int PWID = 2,
  parameter int BLEN = 256,
  parameter int PLAT = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  hub_linear_fold_sequencer_if.master  bus
);
  localparam int CWID = $clog2(BLEN);
  localparam int DWID = (PLAT > 1) ? $clog2(PLAT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          r_state, w_state_next;
  logic [CWID-1:0] r_cnt, w_cnt_next;
  logic [PWID-1:0] r_part, w_part_next;
  logic [DWID-1:0] r_drain, w_drain_next;
  logic            r_load, r_done, r_sel;
  logic            w_load_next, w_done_next, w_sel_next;
  logic            w_run, w_clr_src;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_part  <= '0;
      r_drain <= '0;
      r_load  <= 1'b0;
      r_done  <= 1'b0;
      r_sel   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_part  <= w_part_next;
      r_drain <= w_drain_next;
      r_load  <= w_load_next;
      r_done  <= w_done_next;
      r_sel   <= w_sel_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_part_next  = r_part;
    w_drain_next = r_drain;
    case (r_state)
      S_IDLE: if (bus.start) w_state_next = S_LOAD;
      S_LOAD: begin
        w_state_next = S_RUN;
        w_cnt_next   = '0;
        w_part_next  = '0;
      end
      S_RUN: begin
        if (r_cnt == CWID'(BLEN - 1)) begin
          w_cnt_next = '0;
          // part saturates at FOLD-1; the last part leaves RUN instead of wrapping
          if (r_part < PWID'(FOLD - 1)) begin
            w_part_next = r_part + PWID'(1);
          end else if (PLAT == 0) begin
            w_state_next = S_DONE;
          end else begin
            w_state_next = S_DRAIN;
            w_drain_next = '0;
          end
        end else begin
          w_cnt_next = r_cnt + CWID'(1);
        end
      end
      S_DRAIN: begin
        if (r_drain == DWID'(PLAT - 1)) w_state_next = S_DONE;
        else                            w_drain_next = r_drain + DWID'(1);
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Registered strobes decode the next state so they line up with the state itself.
  always_comb begin
    w_load_next = (w_state_next == S_LOAD);
    w_done_next = (w_state_next == S_DONE);
    w_sel_next  = r_sel ^ w_done_next;
  end

  assign w_run       = (r_state == S_RUN);
  assign w_clr_src   = w_run && (r_part == '0) && (r_cnt == '0);
  assign bus.ready   = (r_state == S_IDLE);
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.load    = r_load;
  assign bus.done    = r_done;
  assign bus.sel     = r_sel;
  assign bus.partMul = r_part;

  generate
    if (PLAT == 0) begin : g_nodly
      assign bus.accValid = w_run;
      assign bus.clear    = w_clr_src;
      assign bus.partAcc  = r_part;
    end else begin : g_dly
      logic [PLAT-1:0] r_acc_sr;
      logic [PLAT-1:0] r_clr_sr;
      logic [PWID-1:0] r_pacc_sr [PLAT];

      // Keeps shifting outside RUN so partAcc settles on the last part.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_acc_sr <= '0;
          r_clr_sr <= '0;
          for (int i = 0; i < PLAT; i++) r_pacc_sr[i] <= '0;
        end else begin
          r_acc_sr[0]  <= w_run;
          r_clr_sr[0]  <= w_clr_src;
          r_pacc_sr[0] <= r_part;
          for (int i = 1; i < PLAT; i++) begin
            r_acc_sr[i]  <= r_acc_sr[i-1];
            r_clr_sr[i]  <= r_clr_sr[i-1];
            r_pacc_sr[i] <= r_pacc_sr[i-1];
          end
        end
      end

      assign bus.accValid = r_acc_sr[PLAT-1];
      assign bus.clear    = r_clr_sr[PLAT-1];
      assign bus.partAcc  = r_pacc_sr[PLAT-1];
    end
  endgenerate
endmodule

// File: tb/tb_hub_linear_fold_sequencer.sv
// Drives two sequencer configurations against a timing-formula model and a done scoreboard.
module tb_hub_linear_fold_sequencer;
  localparam int PW  = 2;
  localparam int BIG = 1000000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rn0, rn1;
  hub_linear_fold_sequencer_if #(.PWID(PW)) if0 ();
  hub_linear_fold_sequencer_if #(.PWID(PW)) if1 ();

  hub_linear_fold_sequencer #(.FOLD(4), .PWID(PW), .BLEN(8), .PLAT(2)) dut0 (
    .clk(clk), .rst_n(rn0), .bus(if0.master));
  hub_linear_fold_sequencer #(.FOLD(1), .PWID(PW), .BLEN(2), .PLAT(0)) dut1 (
    .clk(clk), .rst_n(rn1), .bus(if1.master));

  typedef struct {int cyc; bit sel;} exp_t;
  exp_t q0[$];
  exp_t q1[$];

  int mf[2] = '{4, 1};
  int mb[2] = '{8, 2};
  int mp[2] = '{2, 0};
  int acc[2];
  int base[2];
  bit sel0[2];
  bit mvalid[2] = '{1'b0, 1'b0};
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int pm_at(int f, int b, int r, int bs);
    if (r < 2) return bs;
    if (r < 2 + f * b) return (r - 2) / b;
    return f - 1;
  endfunction

  // Vector: ready busy load partMul[1:0] partAcc[1:0] accValid clear sel done
  function automatic logic [10:0] exp_vec(int k, int r);
    int f = mf[k];
    int b = mb[k];
    int p = mp[k];
    int fb = f * b;
    bit rdy;
    logic [1:0] pm, pa;
    rdy = (r < 1) || (r >= 3 + fb + p);
    pm  = 2'(pm_at(f, b, r, base[k]));
    pa  = 2'(pm_at(f, b, r - p, base[k]));
    return {rdy, !rdy, r == 1, pm, pa, (r >= 2 + p) && (r <= 1 + fb + p),
            r == 2 + p, (r >= 2 + fb + p) ? ~sel0[k] : sel0[k], r == 2 + fb + p};
  endfunction

  function automatic logic [10:0] obs_vec(int k);
    if (k == 0)
      return {if0.ready, if0.busy, if0.load, if0.partMul, if0.partAcc,
              if0.accValid, if0.clear, if0.sel, if0.done};
    return {if1.ready, if1.busy, if1.load, if1.partMul, if1.partAcc,
            if1.accValid, if1.clear, if1.sel, if1.done};
  endfunction

  task automatic sb_pop(input int k, input bit obs_sel);
    exp_t e;
    int sz;
    sz = (k == 0) ? q0.size() : q1.size();
    chk($sformatf("i%0d_c%0d_done_expected", k, cyc), 32'(sz), 32'd1);
    if (sz > 0) begin
      e = (k == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("i%0d_done_cycle", k), 32'(cyc), 32'(e.cyc));
      chk($sformatf("i%0d_done_sel", k), {31'd0, obs_sel}, {31'd0, e.sel});
      $display("inst %0d: inference done at cycle %0d (want %0d), sel=%0d", k, cyc, e.cyc, obs_sel);
    end
  endtask

  task automatic step(input bit s0, input bit r0, input bit s1, input bit r1);
    for (int k = 0; k < 2; k++) begin
      bit sv, rv;
      int r;
      logic [10:0] e, o;
      exp_t t;
      sv = (k == 0) ? s0 : s1;
      rv = (k == 0) ? r0 : r1;
      if (mvalid[k]) begin
        r = cyc - acc[k];
        e = exp_vec(k, r);
        o = obs_vec(k);
        chk($sformatf("i%0d_c%0d_outs", k, cyc), {21'd0, o}, {21'd0, e});
        if (o[0] === 1'b1) sb_pop(k, o[1]);
        if (rv && sv && e[10]) begin
          base[k] = int'(e[7:6]);
          sel0[k] = e[1];
          acc[k]  = cyc;
          t.cyc   = cyc + 2 + mf[k] * mb[k] + mp[k];
          t.sel   = ~e[1];
          if (k == 0) q0.push_back(t);
          else        q1.push_back(t);
        end
      end
      if (!rv) begin
        mvalid[k] = 1'b1;
        acc[k]    = BIG;
        base[k]   = 0;
        sel0[k]   = 1'b0;
        if (k == 0) q0.delete();
        else        q1.delete();
      end
    end
    if0.start = s0;
    rn0       = r0;
    if1.start = s1;
    rn1       = r1;
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Full inference, then back-to-back start on the first ready cycle with start held while busy
    step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(36);
    for (int i = 0; i < 37; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(6);

    // Abort by reset in cycle 15, then a clean inference
    step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(14);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(40);

    // Minimal configuration: FOLD=1, BLEN=2, PLAT=0, back-to-back
    step(1'b0, 1'b1, 1'b1, 1'b1);
    idle(4);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    idle(8);

    chk("i0_sb_empty", 32'(q0.size()), 32'd0);
    chk("i1_sb_empty", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
